// File: rtl/uart_pkg.sv
// Shared UART receiver types and default frame geometry.
package uart_pkg;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
`ifdef UART_RX_PARITY_EN
    , ST_PARITY
`endif
  } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; 2 sys_clk latency, no backpressure.
// Resets to 1 so the idle-high line never looks like a start edge out of reset.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic reset,
  input  logic i_rx,
  output logic o_rxs
);

  logic [1:0] r_sync;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], i_rx};
  end

  assign o_rxs = r_sync[1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver; byte valid 1 sys_clk after the stop-bit mid-sample tick.
// No backpressure: an unaccepted byte is overwritten and flagged sticky overrun. Parity via UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 smp_tick,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_rxs, w_mid, w_wrap, w_last_bit, w_done, w_accept;
`ifdef UART_RX_PARITY_EN
  logic                 r_par;
`endif

  uart_rx_sync u_sync (
    .sys_clk (sys_clk),
    .reset   (reset),
    .i_rx    (rx),
    .o_rxs   (w_rxs)
  );

  assign w_mid      = (r_cnt == MID);
  assign w_wrap     = (r_cnt == LAST);
  assign w_last_bit = (r_bit_idx == BW'(DATA_BITS - 1));
  assign w_done     = smp_tick && w_mid && (r_state == ST_STOP);
  assign w_accept   = rx_valid && rx_ack;

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (smp_tick) begin
      w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          w_cnt_nxt = '0;
          if (!w_rxs) w_state_nxt = ST_START;
        end
        ST_START: begin
          if (w_mid && w_rxs) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (w_wrap) begin
            w_state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
`ifdef UART_RX_PARITY_EN
          if (w_wrap && w_last_bit) w_state_nxt = ST_PARITY;
`else
          if (w_wrap && w_last_bit) w_state_nxt = ST_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_wrap) w_state_nxt = ST_STOP;
        end
`endif
        // Leave at mid-stop so a start edge in the second half is caught.
        ST_STOP: begin
          if (w_mid) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else if (smp_tick) begin
      if (r_state == ST_DATA) begin
        if (w_mid)  r_shift[r_bit_idx] <= w_rxs;
        if (w_wrap) r_bit_idx <= w_last_bit ? '0 : r_bit_idx + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (r_state == ST_PARITY && w_mid) r_par <= w_rxs;
`endif
    end
  end

  // A completion wins over an accept; overrun only when the old byte was never taken.
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else if (w_done) begin
      rx_data    <= r_shift;
      rx_valid   <= 1'b1;
      frame_err  <= ~w_rxs;
      if (rx_valid) overrun <= ~rx_ack;
`ifdef UART_RX_PARITY_EN
      parity_err <= ^{r_shift, r_par};
`endif
    end else if (w_accept) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one tick every 4 clocks, 16 ticks per bit.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int TPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_T = 9 + TPB * 10;
`else
  localparam int STOP_T = 9 + TPB * 9;
`endif

  logic       sys_clk  = 1'b0;
  logic       reset    = 1'b0;
  logic       smp_tick = 1'b0;
  logic       rx       = 1'b1;
  logic       rx_ack   = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int   cyc      = 0;
  int   ack_cyc  = -1;
  int   rise_cyc = -1;
  int   n_rise   = 0;
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   c0;
  logic vld_q    = 1'b0;

  always #5 sys_clk = ~sys_clk;

  uart_rx dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .smp_tick  (smp_tick),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Observe outputs on the falling edge, then set inputs for the next rising edge.
  task automatic clk_cycle();
    @(negedge sys_clk);
    cyc++;
    smp_tick = (cyc % 4 == 0);
    rx_ack   = (cyc == ack_cyc);
    if (rx_valid && !vld_q) begin
      n_rise++;
      if (rise_cyc < 0) rise_cyc = cyc;
    end
    vld_q = rx_valid;
  endtask

  task automatic align();
    while (cyc % 4 != 0) clk_cycle();
  endtask

  task automatic idle(input int ticks);
    rx = 1'b1;
    repeat (4 * ticks) clk_cycle();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (4 * TPB) clk_cycle();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                            input logic ack_at_done, output int start_cyc);
    align();
    start_cyc = cyc;
    rise_cyc  = -1;
    if (ack_at_done) ack_cyc = cyc + 4 * STOP_T;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
    send_bit(stop_b);
    rx = 1'b1;
  endtask

  task automatic chk_frame(input string tag, input int start_cyc, input logic chk_lat,
                           input logic [7:0] exp_d, input logic exp_fe);
    if (chk_lat) chk({tag, "_latency"}, 32'(rise_cyc), 32'(start_cyc + 4 * STOP_T + 1));
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_data"}, 32'(rx_data), 32'(exp_d));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(exp_fe));
  endtask

  task automatic do_ack();
    ack_cyc = cyc + 1;
    clk_cycle();
    clk_cycle();
  endtask

  initial begin
    repeat (3) clk_cycle();
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
`ifdef UART_RX_PARITY_EN
    chk("rst_perr", 32'(parity_err), 32'd0);
`endif
    reset = 1'b1;
    idle(4);

    send_frame(8'h55, 1'b1, 1'b0, 1'b0, c0);
    chk_frame("b55", c0, 1'b1, 8'h55, 1'b0);
    chk("b55_ovr", 32'(overrun), 32'd0);

    // Completion coinciding with the accept of the pending 0x55.
    send_frame(8'hC6, 1'b1, 1'b0, 1'b1, c0);
    ack_cyc = -1;
    chk_frame("bC6", c0, 1'b0, 8'hC6, 1'b0);
    chk("bC6_ovr", 32'(overrun), 32'd0);
    do_ack();
    chk("ack_valid", 32'(rx_valid), 32'd0);
    do_ack();
    chk("stray_ack_valid", 32'(rx_valid), 32'd0);
    chk("stray_ack_ovr", 32'(overrun), 32'd0);

    // False start: low for 4 ticks only.
    align();
    c0 = cyc;
    rx = 1'b0;
    repeat (16) clk_cycle();
    rx = 1'b1;
    repeat (17) clk_cycle();
    chk("fs_before_mid", 32'(dut.r_state), 32'(ST_START));
    repeat (4) clk_cycle();
    chk("fs_after_mid", 32'(dut.r_state), 32'(ST_IDLE));
    idle(32);
    chk("fs_valid", 32'(rx_valid), 32'd0);

    send_frame(8'hA3, 1'b0, 1'b0, 1'b0, c0);
    chk_frame("bA3", c0, 1'b1, 8'hA3, 1'b1);
    idle(32);
    chk("bA3_hold", 32'(rx_data), 32'hA3);
    do_ack();

    send_frame(8'h12, 1'b1, 1'b0, 1'b0, c0);
    chk_frame("b12", c0, 1'b1, 8'h12, 1'b0);
    chk("b12_ovr", 32'(overrun), 32'd0);
    send_frame(8'h34, 1'b1, 1'b0, 1'b0, c0);
    chk_frame("b34", c0, 1'b0, 8'h34, 1'b0);
    chk("b34_ovr", 32'(overrun), 32'd1);
    do_ack();
    chk("ovr_ack_valid", 32'(rx_valid), 32'd0);
    chk("ovr_ack_ovr", 32'(overrun), 32'd0);

    // Reset in the middle of data bit 3 of 0xFF.
    align();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (32) clk_cycle();
    reset = 1'b0;
    clk_cycle();
    chk("mid_rst_data", 32'(rx_data), 32'h0);
    chk("mid_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    n_rise = 0;
    repeat (8) clk_cycle();
    reset = 1'b1;
    repeat (32 - 9) clk_cycle();
    idle(TPB * 6);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, c0);
    chk_frame("b0F", c0, 1'b1, 8'h0F, 1'b0);
    chk("b0F_count", 32'(n_rise), 32'd1);
    do_ack();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, c0);
    chk_frame("p07_ok", c0, 1'b1, 8'h07, 1'b0);
    chk("p07_ok_perr", 32'(parity_err), 32'd0);
    do_ack();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, c0);
    chk_frame("p07_bad", c0, 1'b1, 8'h07, 1'b0);
    chk("p07_bad_perr", 32'(parity_err), 32'd1);
    do_ack();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame, sent LSB first.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, number of smp_tick pulses per bit period.
REQ-003 SHALL have port sys_clk  in  1  system clock; all state on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port smp_tick  in  1  sample enable, 1-cycle pulse at OVERSAMPLE x baud rate.
REQ-006 SHALL have port rx  in  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_ack  in  1  consumer accepts rx_data.
REQ-008 SHALL have port rx_data  out  DATA_BITS  last received byte.
REQ-009 SHALL have port rx_valid  out  1  rx_data holds an unaccepted byte.
REQ-010 SHALL have port frame_err  out  1  stop bit of the byte in rx_data sampled low.
REQ-011 SHALL have port overrun  out  1  a byte completed while rx_valid=1 and rx_ack=0.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all line decisions use the synchronized value rxs.
REQ-013 SHALL advance the bit-phase counter cnt (0..OVERSAMPLE-1, wraps to 0) only on cycles with smp_tick=1.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, STOP, plus PARITY under REQ-026.
REQ-015 In IDLE, on a smp_tick with rxs=0, SHALL go to START with cnt=0.
REQ-016 In START, at the tick where cnt=OVERSAMPLE/2-1 (7), SHALL return to IDLE if rxs=1 (false start, no output); otherwise SHALL continue, and go to DATA when cnt wraps.
REQ-017 In DATA, at cnt=7, SHALL shift rxs into bit index i (LSB first); at wrap after bit DATA_BITS-1 SHALL go to STOP (or PARITY).
REQ-018 In STOP, at cnt=7, SHALL sample the stop bit and return to IDLE on that same tick, so a start edge in the second half of the stop bit is detected.
REQ-019 On the cycle after the stop sample: SHALL load rx_data, set frame_err to the inverted stop sample, and set rx_valid=1; a frame_err byte is still delivered.
REQ-020 rx_valid SHALL clear on a cycle with rx_valid=1 and rx_ack=1; rx_ack while rx_valid=0 SHALL be ignored.
REQ-021 If a completion and rx_ack coincide, SHALL keep rx_valid=1 with the new byte and set no overrun.
REQ-022 If a completion occurs with rx_valid=1 and rx_ack=0, SHALL overwrite rx_data/frame_err and set overrun=1 (sticky); overrun SHALL clear with the next accepted rx_ack.
REQ-023 Latency from the stop-bit mid-sample tick to rx_valid=1 SHALL be exactly 1 sys_clk.

Reset
REQ-024 While reset=0: FSM=IDLE, cnt=0, synchronizer flops=1, rx_data=0, rx_valid=0, frame_err=0, overrun=0.
REQ-025 Reset asserted mid-frame SHALL discard the partial byte; after release SHALL wait for a new falling edge.

Configuration
REQ-026 With UART_RX_PARITY_EN defined: SHALL add state PARITY after DATA, sampling one even-parity bit at cnt=7, plus output port parity_err (1 bit, reset 0), loaded with rx_data and indicating even parity over data+parity bit failed.
REQ-027 Without UART_RX_PARITY_EN: there SHALL be no PARITY state and no parity_err port; the frame is start + DATA_BITS + stop.

Structure
REQ-028 SHALL place the FSM state enum and the default OVERSAMPLE/DATA_BITS constants in shared package uart_pkg.
REQ-029 SHALL put the 2-flop synchronizer in sub-module uart_rx_sync (reset value 1); the rest stays flat in uart_rx.

Verification
REQ-030 Frame 0x55, valid stop, smp_tick every 4 clocks -> rx_valid rises 1 clk after stop mid-sample, rx_data=0x55, frame_err=0.
REQ-031 rx low for 4 ticks then high -> FSM back in IDLE at cnt=7, rx_valid stays 0.
REQ-032 Frame 0xA3 with stop bit=0 -> rx_data=0xA3, frame_err=1, rx_valid=1.
REQ-033 Bytes 0x12 then 0x34 back-to-back, no rx_ack -> rx_data=0x34, overrun=1; rx_ack -> rx_valid=0, overrun=0.
REQ-034 reset=0 during bit 3 of 0xFF, then frame 0x0F -> only 0x0F delivered, no frame_err.
REQ-035 With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.
